// File: rtl/seq_debug_cmd_mailbox.sv
// Host-to-sequencer debug command mailbox on the Avalon-MM bus.
// Optional busy timeout is enabled with `define SEQ_DEBUG_CMD_TIMEOUT_EN.
module seq_debug_cmd_mailbox #(
  parameter logic [31:0] BASE_ADDR      = 32'h000153c0,
  parameter int          ADDR_W         = 20,
  parameter int          NUM_PARAMS     = 4,
  parameter int          CMD_W          = 16,
  parameter int          RES_W          = 8,
  parameter logic [31:0] DEBUG_ID       = 32'h5EDB0001,
  parameter int          TIMEOUT_CYCLES = 65535
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [ADDR_W-1:0]          avl_address,
  input  logic                       avl_read,
  input  logic                       avl_write,
  input  logic [31:0]                avl_writedata,
  output logic [31:0]                avl_readdata,
  output logic                       avl_readdatavalid,
  output logic                       cmd_valid,
  input  logic                       cmd_ready,
  output logic [CMD_W-1:0]           cmd_code,
  output logic [NUM_PARAMS*32-1:0]   cmd_params,
  input  logic                       core_done,
  input  logic [RES_W-1:0]           core_result
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    BUSY    = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] BASE = BASE_ADDR[ADDR_W-1:0];

  state_t                     state;
  logic                       overflow;
  logic                       timeout;
  logic [RES_W-1:0]           result;
  logic [31:0]                shadow [NUM_PARAMS];
  logic [NUM_PARAMS*32-1:0]   shadow_flat;
  logic [ADDR_W-1:0]          offset;
  logic                       in_window;
  logic                       is_id;
  logic                       is_req;
  logic                       is_status;
  logic [NUM_PARAMS-1:0]      param_hit;
  logic [31:0]                status_word;
  logic [31:0]                rd_data;
`ifdef SEQ_DEBUG_CMD_TIMEOUT_EN
  logic [31:0]                busy_cnt;
`endif

  // Addresses below the base would wrap the subtraction, so gate them out explicitly.
  assign offset    = avl_address - BASE;
  assign in_window = (avl_address >= BASE);
  assign is_id     = in_window && (offset == ADDR_W'(32'h0));
  assign is_req    = in_window && (offset == ADDR_W'(32'h8));
  assign is_status = in_window && (offset == ADDR_W'(32'hC));

  always_comb begin
    param_hit   = '0;
    shadow_flat = '0;
    for (int i = 0; i < NUM_PARAMS; i++) begin
      param_hit[i]          = in_window && (offset == ADDR_W'(16 + 4 * i));
      shadow_flat[32*i +: 32] = shadow[i];
    end
  end

  assign status_word = {16'h0000, 8'(result), 4'h0, timeout, overflow, state};

  always_comb begin
    rd_data = '0;
    if (is_id)     rd_data = DEBUG_ID;
    if (is_status) rd_data = status_word;
    for (int i = 0; i < NUM_PARAMS; i++)
      if (param_hit[i]) rd_data = shadow[i];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      avl_readdata      <= '0;
      avl_readdatavalid <= 1'b0;
      cmd_valid         <= 1'b0;
      cmd_code          <= '0;
      cmd_params        <= '0;
      overflow          <= 1'b0;
      timeout           <= 1'b0;
      result            <= '0;
      state             <= IDLE;
      for (int i = 0; i < NUM_PARAMS; i++) shadow[i] <= '0;
`ifdef SEQ_DEBUG_CMD_TIMEOUT_EN
      busy_cnt          <= '0;
`endif
    end else begin
      avl_readdatavalid <= avl_read;
      avl_readdata      <= avl_read ? rd_data : 32'h0;

      for (int i = 0; i < NUM_PARAMS; i++)
        if (avl_write && param_hit[i]) shadow[i] <= avl_writedata;

      // A request arriving while a command is in flight is dropped but remembered.
      if (avl_write && is_req && (state != IDLE)) overflow <= 1'b1;

      case (state)
        IDLE: begin
          if (avl_write && is_req) begin
            cmd_code   <= avl_writedata[CMD_W-1:0];
            cmd_params <= shadow_flat;
            cmd_valid  <= 1'b1;
            state      <= PENDING;
          end
        end
        PENDING: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= BUSY;
`ifdef SEQ_DEBUG_CMD_TIMEOUT_EN
            busy_cnt  <= '0;
`endif
          end
        end
        BUSY: begin
          if (core_done) begin
            result <= core_result;
            state  <= DONE;
          end
`ifdef SEQ_DEBUG_CMD_TIMEOUT_EN
          else if (busy_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
            timeout <= 1'b1;
            result  <= '0;
            state   <= DONE;
          end else begin
            busy_cnt <= busy_cnt + 32'd1;
          end
`endif
        end
        DONE: begin
          // The host acknowledges completion by reading the status word.
          if (avl_read && is_status) begin
            overflow <= 1'b0;
            timeout  <= 1'b0;
            result   <= '0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
